// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with start/ready/done handshake.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic            r_spec;
  logic [XLEN-1:0] r_spec_res;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;

  logic            w_is_div;
  logic            w_a_sgn, w_b_sgn;
  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_spec;
  logic [XLEN-1:0] w_spec_res;
  logic            w_neg;
  logic            w_last;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rsh;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_nx, w_lo_nx;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_q, w_r, w_fin;
  logic            w_mull, w_mulh, w_divq, w_divr;

  assign ready  = (r_state == S_IDLE);
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

  // Operand decode, valid only in the accepting cycle
  assign w_is_div = funct3[2];
  assign w_a_sgn  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_sgn  = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                    (funct3 == 3'b110);
  assign w_a_neg  = w_a_sgn & a[XLEN-1];
  assign w_b_neg  = w_b_sgn & b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_div0   = w_is_div & (b == '0);
  assign w_ovf    = w_is_div & ~funct3[0] & (a == MIN_INT) & (b == '1);
  assign w_spec   = w_div0 | w_ovf;
  assign w_neg    = (funct3 == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_last   = (r_cnt == CW'(XLEN-1));

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = funct3[1] ? a : '1;
    else if (w_ovf)
      w_spec_res = funct3[1] ? '0 : MIN_INT;
  end

  // One iteration step: hi/lo hold product or remainder/quotient
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_rsh - {1'b0, r_b};

  always_comb begin
    w_hi_nx = w_sum[XLEN:1];
    w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_f3[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_nx = w_diff[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nx = w_rsh[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_q      = r_neg ? -w_lo_nx : w_lo_nx;
  assign w_r      = r_neg ? -w_hi_nx : w_hi_nx;

  assign w_mull = (r_f3 == 3'b000);
  assign w_mulh = ~r_f3[2] & (r_f3[1:0] != 2'b00);
  assign w_divq = r_f3[2] & ~r_f3[1];
  assign w_divr = r_f3[2] & r_f3[1];

  always_comb begin
    w_fin = '0;
    unique case (1'b1)
      w_mull:  w_fin = w_prod_s[XLEN-1:0];
      w_mulh:  w_fin = w_prod_s[2*XLEN-1:XLEN];
      w_divq:  w_fin = w_q;
      w_divr:  w_fin = w_r;
      default: w_fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start)
          w_next = (EARLY_OUT && w_spec) ? S_DONE : S_CALC;
      S_CALC:
        if (w_last)
          w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_f3       <= '0;
      r_neg      <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_result   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (start) begin
            r_cnt      <= '0;
            r_f3       <= funct3;
            r_neg      <= w_neg;
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            r_hi       <= '0;
            r_lo       <= w_is_div ? w_a_mag : w_b_mag;
            r_b        <= w_is_div ? w_b_mag : w_a_mag;
            if (EARLY_OUT && w_spec)
              r_result <= w_spec_res;
          end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          if (w_last)
            r_result <= r_spec ? r_spec_res : w_fin;
        end
        default: ;
      endcase
    end
  end

endmodule
